// File: rtl/parameterized_stream_demux.sv
// parameterized_stream_demux
// Distributes one valid/ready input stream to OUT_NUM output lanes chosen per
// transfer by i_sel. Each lane owns a single-entry register so every consumer
// sees registered data and applies its own backpressure. Transfers addressed
// to a lane index >= OUT_NUM are accepted, dropped, and latch a sticky error.
module parameterized_stream_demux #(
  parameter  int BW_DATA = 32,
  parameter  int OUT_NUM = 4,
  localparam int BW_SEL  = $clog2(OUT_NUM)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [BW_DATA-1:0]         i_data,
  input  logic [BW_SEL-1:0]          i_sel,
  output logic                       o_ready,
  output logic [OUT_NUM-1:0]         o_valid,
  output logic [OUT_NUM*BW_DATA-1:0] o_data,
  input  logic [OUT_NUM-1:0]         i_ready,
  output logic                       o_err
);

  // Lane storage: packed so lane k lands at o_data[k*BW_DATA +: BW_DATA].
  logic [OUT_NUM-1:0][BW_DATA-1:0] data_p0;
  logic [OUT_NUM-1:0]              vld_p0;
  logic                            err_p0;

  logic [OUT_NUM-1:0] sel_hit;
  logic               in_range;
  logic               lane_rdy;
  logic               acc;

  // Decode i_sel into a one-hot lane hit and pick up the addressed lane's
  // pass-through readiness (empty, or being drained this cycle). Indices
  // with no matching lane leave sel_hit all-zero, which marks the transfer
  // as out of range without ever indexing past the last lane.
  always_comb begin
    sel_hit  = '0;
    lane_rdy = 1'b0;
    for (int k = 0; k < OUT_NUM; k++) begin
      if (i_sel == BW_SEL'(k)) begin
        sel_hit[k] = 1'b1;
        lane_rdy   = ~vld_p0[k] | i_ready[k];
      end
    end
    in_range = |sel_hit;
    // Out-of-range words are always taken so the producer never stalls on them.
    o_ready  = in_range ? lane_rdy : 1'b1;
    acc      = i_valid & o_ready;
  end

  // ---- stage p0: per-lane holding registers and sticky error ----
  // Load wins over drain so a lane emptied and refilled in the same cycle
  // stays valid with the new word; data only moves on load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p0  <= '0;
      data_p0 <= '0;
      err_p0  <= 1'b0;
    end else begin
      for (int k = 0; k < OUT_NUM; k++) begin
        if (acc && sel_hit[k]) begin
          data_p0[k] <= i_data;
          vld_p0[k]  <= 1'b1;
        end else if (i_ready[k]) begin
          vld_p0[k]  <= 1'b0;
        end
      end
      if (acc && !in_range) begin
        err_p0 <= 1'b1;
      end
    end
  end

  assign o_valid = vld_p0;
  assign o_data  = data_p0;
  assign o_err   = err_p0;

endmodule

// File: tb/tb_parameterized_stream_demux.sv
// Bench for parameterized_stream_demux: a 4-lane instance driven by a vector
// table and randomized traffic against a lane-occupancy model, and a 3-lane
// instance used for the out-of-range / sticky error behaviour.
module tb_parameterized_stream_demux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-lane instance
  logic          valid4;
  logic [31:0]   data4;
  logic [1:0]    sel4;
  logic [3:0]    ready4;
  logic          ordy4;
  logic [3:0]    ovld4;
  logic [127:0]  odata4;
  logic          oerr4;

  // 3-lane instance
  logic          valid3;
  logic [31:0]   data3;
  logic [1:0]    sel3;
  logic [2:0]    ready3;
  logic          ordy3;
  logic [2:0]    ovld3;
  logic [95:0]   odata3;
  logic          oerr3;

  parameterized_stream_demux #(.BW_DATA(32), .OUT_NUM(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid4), .i_data(data4), .i_sel(sel4),
    .o_ready(ordy4), .o_valid(ovld4), .o_data(odata4), .i_ready(ready4), .o_err(oerr4)
  );

  parameterized_stream_demux #(.BW_DATA(32), .OUT_NUM(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid3), .i_data(data3), .i_sel(sel3),
    .o_ready(ordy3), .o_valid(ovld3), .o_data(odata3), .i_ready(ready3), .o_err(oerr3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model of the 4-lane instance: each lane is a one-slot box that
  // is either empty or holds a word.
  bit                [3:0]  m_full;
  logic [3:0][31:0]         m_word;
  bit                       m_err;
  bit                       last_acc;

  function automatic bit m_ready();
    // Every 2-bit index addresses a real lane in the 4-lane instance.
    return !m_full[sel4] || ready4[sel4];
  endfunction

  function automatic void m_reset();
    m_full = '0;
    m_word = '0;
    m_err  = 1'b0;
  endfunction

  function automatic void m_edge();
    bit taken;
    taken = valid4 && m_ready();
    for (int k = 0; k < 4; k++) begin
      if (taken && sel4 == k) begin
        m_full[k] = 1'b1;
        m_word[k] = data4;
      end else if (m_full[k] && ready4[k]) begin
        m_full[k] = 1'b0;
      end
    end
  endfunction

  // One clock of the 4-lane instance, checked against the model. Inputs are
  // applied at the falling edge before the call.
  task automatic cyc4(input string tag);
    bit er;
    #1;
    er = m_ready();
    last_acc = valid4 && er;
    chk({tag, " o_ready"}, ordy4, er);
    @(posedge clk);
    m_edge();
    #1;
    chk({tag, " o_valid"}, ovld4, m_full);
    chk({tag, " o_data"},  odata4, m_word);
    chk({tag, " o_err"},   oerr4, m_err);
    @(negedge clk);
  endtask

  typedef struct {
    bit          v;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [3:0]  rdy;
    bit          e_rdy;
    logic [3:0]  e_vld;
    int          lane;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit v, input logic [1:0] sel, input logic [31:0] d,
                              input logic [3:0] rdy, input bit e_rdy, input logic [3:0] e_vld,
                              input int lane, input logic [31:0] e_data);
    vec_t r;
    r.v = v; r.sel = sel; r.d = d; r.rdy = rdy;
    r.e_rdy = e_rdy; r.e_vld = e_vld; r.lane = lane; r.e_data = e_data;
    tbl.push_back(r);
  endfunction

  initial begin
    // Single routing, hold for 10 cycles, then drain
    add(1, 2, 32'hA5A5_0002, 4'b0000, 1, 4'b0100, 2, 32'hA5A5_0002);
    for (int i = 0; i < 10; i++)
      add(0, 2, 32'h0, 4'b0000, 0, 4'b0100, 2, 32'hA5A5_0002);
    add(0, 2, 32'h0, 4'b0100, 1, 4'b0000, 2, 32'hA5A5_0002);
    // Backpressure on lane 1
    add(1, 1, 32'hAA,   4'b0000, 1, 4'b0010, 1, 32'hAA);
    add(1, 1, 32'h11,   4'b0000, 0, 4'b0010, 1, 32'hAA);
    add(1, 1, 32'h11,   4'b0010, 1, 4'b0010, 1, 32'h11);
    add(0, 1, 32'h0,    4'b0010, 1, 4'b0000, 1, 32'h11);
    // Streaming 0..7 into lane 3 with the consumer always ready
    for (int i = 0; i < 8; i++)
      add(1, 3, 32'(i), 4'b1000, 1, 4'b1000, 3, 32'(i));
    add(0, 3, 32'h0, 4'b1000, 1, 4'b0000, 3, 32'h7);
    // Parallel drain with a same-cycle refill of lane 0
    add(1, 0, 32'h10, 4'b0000, 1, 4'b0001, 0, 32'h10);
    add(1, 1, 32'h11, 4'b0000, 1, 4'b0011, 1, 32'h11);
    add(1, 2, 32'h12, 4'b0000, 1, 4'b0111, 2, 32'h12);
    add(1, 3, 32'h13, 4'b0000, 1, 4'b1111, 3, 32'h13);
    add(1, 0, 32'h20, 4'b1111, 1, 4'b0001, 0, 32'h20);
    add(0, 1, 32'h0,  4'b0000, 1, 4'b0001, 1, 32'h11);
    add(0, 0, 32'h0,  4'b1111, 1, 4'b0000, 0, 32'h20);

    rst = 1'b1;
    valid4 = 0; data4 = '0; sel4 = 2'd2; ready4 = '0;
    valid3 = 0; data3 = '0; sel3 = '0;   ready3 = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset o_valid", ovld4, 4'b0000);
    chk("reset o_data",  odata4, 128'h0);
    chk("reset o_err",   oerr4, 1'b0);
    chk("reset o_ready", ordy4, 1'b1);
    chk("reset3 o_err",  oerr3, 1'b0);
    rst = 1'b0;

    // Vector table
    foreach (tbl[i]) begin
      valid4 = tbl[i].v; sel4 = tbl[i].sel; data4 = tbl[i].d; ready4 = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d o_ready", i), ordy4, tbl[i].e_rdy);
      cyc4($sformatf("tbl%0d model", i));
      chk($sformatf("tbl%0d o_valid", i), ovld4, tbl[i].e_vld);
      chk($sformatf("tbl%0d lane%0d", i, tbl[i].lane),
          odata4[tbl[i].lane*32 +: 32], tbl[i].e_data);
    end

    // Randomized traffic; the producer holds data/sel while stalled
    last_acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(valid4 && !last_acc)) begin
        valid4 = ($urandom_range(0, 3) != 0);
        sel4   = 2'($urandom_range(0, 3));
        data4  = $urandom;
      end
      ready4 = 4'($urandom);
      cyc4($sformatf("rnd%0d", i));
    end
    valid4 = 0; ready4 = '0;

    // Out-of-range handling on the 3-lane instance
    valid3 = 1; sel3 = 2'd1; data3 = 32'h42; ready3 = 3'b000;
    #1; chk("oor load o_ready", ordy3, 1'b1);
    @(posedge clk); #1;
    chk("oor load o_valid", ovld3, 3'b010);
    chk("oor load lane1", odata3[63:32], 32'h42);
    @(negedge clk);
    sel3 = 2'd3; data3 = 32'hFF;
    #1; chk("oor drop o_ready", ordy3, 1'b1);
    @(posedge clk); #1;
    chk("oor drop o_valid", ovld3, 3'b010);
    chk("oor drop lane1", odata3[63:32], 32'h42);
    chk("oor drop o_err", oerr3, 1'b1);
    @(negedge clk);
    sel3 = 2'd0; data3 = 32'h5; ready3 = 3'b010;
    @(posedge clk); #1;
    chk("oor after o_valid", ovld3, 3'b001);
    chk("oor after lane0", odata3[31:0], 32'h5);
    chk("oor after o_err", oerr3, 1'b1);
    @(negedge clk);
    valid3 = 0; ready3 = '0;
    @(posedge clk); #1;
    chk("oor idle o_err", oerr3, 1'b1);
    @(negedge clk);

    // Asynchronous reset mid-operation
    valid4 = 1; sel4 = 2'd2; data4 = 32'hDEAD_BEEF; ready4 = '0;
    cyc4("prefill");
    valid4 = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("async o_valid", ovld4, 4'b0000);
    chk("async o_data",  odata4, 128'h0);
    chk("async o_err3",  oerr3, 1'b0);
    chk("async o_ready", ordy4, 1'b1);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("post-reset o_valid", ovld4, 4'b0000);

    last_acc = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!(valid4 && !last_acc)) begin
        valid4 = $urandom_range(0, 1) != 0;
        sel4   = 2'($urandom_range(0, 3));
        data4  = $urandom;
      end
      ready4 = 4'($urandom);
      cyc4($sformatf("rnd2_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parameterized_stream_demux.md
# parameterized_stream_demux

Routes one valid/ready input stream to one of `OUT_NUM` output streams selected per transfer by `i_sel`. It is the distributing counterpart of the N-to-1 parameterized mux, and sits where a shared producer feeds several independent consumers. Each output has a single-entry register stage, so each consumer sees registered data and independent backpressure. A sticky error flag reports transfers addressed to non-existent outputs.

## Interface
- `BW_DATA`, default 32: data width of the input and of each output lane.
- `OUT_NUM`, default 4: number of output lanes, 2..256; need not be a power of two.
- `BW_SEL`, derived as `$clog2(OUT_NUM)`: width of `i_sel`. It is a localparam, not user-settable.

Ports:
- `i_clk`  in  1: single clock; all state updates on the rising edge.
- `i_rst`  in  1: asynchronous, active-high reset.
- `i_valid`  in  1: input transfer request.
- `i_data`  in  BW_DATA: input payload.
- `i_sel`  in  BW_SEL: destination lane index, qualified by `i_valid`.
- `o_ready`  out  1: the input transfer is accepted this cycle when both `i_valid` and `o_ready` are 1.
- `o_valid`  out  OUT_NUM: bit k high means lane k holds a word.
- `o_data`  out  OUT_NUM*BW_DATA: flat packed bus. Lane k is `o_data[k*BW_DATA +: BW_DATA]`. Unpacked-array ports are not used.
- `i_ready`  in  OUT_NUM: bit k high means consumer k takes lane k's word this cycle.
- `o_err`  out  1: sticky flag, set when a transfer addresses lane ≥ OUT_NUM.

## Operation
- Per lane k there is one data register `data_q[k]` and one flag `vld_q[k]`. Each lane is empty (`vld_q=0`) or full (`vld_q=1`).
- Input acceptance, `acc = i_valid & o_ready`:
  - If `i_sel < OUT_NUM`: `o_ready = ~vld_q[i_sel] | i_ready[i_sel]`. This is pass-through readiness: a full lane being drained this cycle can be refilled in the same cycle.
  - If `i_sel >= OUT_NUM`: `o_ready = 1`. The word is consumed and dropped, and `o_err` is set. No lane changes.
  - If `i_valid = 0`: `o_ready` still reflects the addressed lane. Consumers must not rely on it.
- Lane k update, every edge:
  - load: `acc & (i_sel==k)` gives `data_q[k] <= i_data` and `vld_q[k] <= 1`.
  - drain only: `vld_q[k] & i_ready[k] & ~load` gives `vld_q[k] <= 0`.
  - If both load and drain happen, `vld_q[k]` stays 1 and the new data replaces the old.
  - Otherwise the lane holds its value. `data_q[k]` changes only on load.
- Lanes other than the selected one drain independently and concurrently.
- `i_ready[k]` while `vld_q[k]=0` has no effect.
- Producer rule: while `i_valid=1` and `o_ready=0`, the producer holds `i_data` and `i_sel` stable. Consumer rule: `i_ready` may toggle freely.
- `o_err` is set on a dropped transfer and is cleared only by reset.

## Timing
- Reset values, applied asynchronously on `i_rst=1`:
  - `o_valid` = 0 (all lanes).
  - `o_data` = 0.
  - `o_err` = 0.
  - `o_ready` then equals 1 for any in-range `i_sel`.
- Reset asserted mid-operation discards all held words immediately. No partial transfer completes after deassertion.
- Latency: a word accepted at edge n appears at `o_valid[sel]=1` with its data immediately after edge n, so it is visible during cycle n+1.
- Throughput: 1 word/cycle to the same lane while that consumer holds `i_ready=1`; 1 word/cycle aggregate otherwise.
- Combinational path from `i_ready[i_sel]` and `i_sel` to `o_ready` is allowed and documented for integration.
- No combinational path from `i_data` or `i_valid` to any output.

## Test plan
- Reset with OUT_NUM=4, BW_DATA=32, `i_rst` pulsed mid-cycle -> `o_valid=4'b0000`, `o_data=0`, `o_err=0` asynchronously. With `i_sel=2` and `i_valid=0`, `o_ready=1`.
- Single routing: `i_sel=2`, `i_data=32'hA5A5_0002`, `i_valid=1` for one cycle, `i_ready=0` -> after the edge `o_valid=4'b0100` and lane 2 = `A5A5_0002`. Lane 2 holds for 10 cycles. Then `i_ready[2]=1` for one cycle -> `o_valid=0`.
- Backpressure: lane 1 full, `i_ready[1]=0`, send `i_sel=1` with `data=0x11` -> `o_ready=0` and lane 1 keeps its old word. Raise `i_ready[1]` -> `o_ready=1` that cycle, and lane 1 = `0x11` next cycle with `o_valid[1]` still 1.
- Streaming: 8 back-to-back words 0..7 to lane 3 with `i_ready[3]=1` -> `o_ready` stays 1 throughout and lane 3 shows 0..7 on consecutive cycles.
- Parallel drain: fill lanes 0..3 with 0x10..0x13, then assert `i_ready=4'b1111` for one cycle while sending `i_sel=0`, `data=0x20` -> next cycle `o_valid=4'b0001` and lane 0 = `0x20`.
- Out of range, OUT_NUM=3: send `i_sel=3`, `data=0xFF` -> `o_ready=1`, no `o_valid` change, `o_err=1` afterward. `o_err` stays 1 through later valid traffic until `i_rst`.
